// File: rtl/monster_pkg.sv
// monster_pkg: shared screen bounds, march FSM states and period helper for the invader formation.
package monster_pkg;
    typedef enum logic [1:0] {IDLE, MARCH, LANDED, CLEARED} march_state_t;
    localparam int SCREEN_W        = 640;
    localparam int SCREEN_H        = 480;
    localparam int MARGIN          = 32;
    localparam int DEF_STEP_PX     = 4;
    localparam int DEF_DROP_PX     = 16;
    localparam int DEF_LEFT_BOUND  = MARGIN;
    localparam int DEF_RIGHT_BOUND = SCREEN_W - MARGIN;
    localparam int DEF_FLOOR_Y     = 416;
    localparam int DEF_INIT_X      = 32;
    localparam int DEF_INIT_Y      = 32;
    function automatic logic [5:0] march_period(input logic [5:0] alive);
        return (alive >> 1) + 6'd1;
    endfunction
endpackage

// File: rtl/march_tick_gen.sv
// march_tick_gen: counts frames while marching and pulses moveTick once per march period.
module march_tick_gen
    import monster_pkg::*;
(
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       run,
    input  logic [5:0] aliveCount,
    output logic       moveTick
);
    logic [5:0] frameCnt_q, frameCnt_d, period;
    // >= lets a period that shrank below the running count fire on the very next frame
    always_comb begin
        period     = march_period(aliveCount);
        moveTick   = run && startOfFrame && (frameCnt_q + 6'd1 >= period);
        frameCnt_d = (!run || moveTick) ? 6'd0 : startOfFrame ? frameCnt_q + 6'd1 : frameCnt_q;
    end
    always_ff @(posedge clk)
        frameCnt_q <= !resetN ? 6'd0 : frameCnt_d;
endmodule

// File: rtl/monster_march_controller.sv
// monster_march_controller: march FSM stepping the invader formation, dropping and reversing at screen edges.
module monster_march_controller
    import monster_pkg::*;
#(
    parameter int STEP_PX     = DEF_STEP_PX,
    parameter int DROP_PX     = DEF_DROP_PX,
    parameter int LEFT_BOUND  = DEF_LEFT_BOUND,
    parameter int RIGHT_BOUND = DEF_RIGHT_BOUND,
    parameter int FLOOR_Y     = DEF_FLOOR_Y,
    parameter int INIT_X      = DEF_INIT_X,
    parameter int INIT_Y      = DEF_INIT_Y
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic [5:0]         aliveCount,
    input  logic [9:0]         formationWidth,
    input  logic [8:0]         formationHeight,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               direction,
    output logic               stepPulse,
    output logic               landed
);
    march_state_t       state_q, state_d;
    logic signed [10:0] x_q, x_d, y_q, y_d;
    logic               dir_q, dir_d, step_q;
    logic               run, move_tick, drop, land;
    logic signed [11:0] x12, right_edge, left_edge, y_drop;
    assign run = (state_q == MARCH) && enable && (aliveCount != 6'd0);
    march_tick_gen u_tick (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .run          (run),
        .aliveCount   (aliveCount),
        .moveTick     (move_tick)
    );
    // edge tests run in 12-bit signed so X + width cannot wrap
    always_comb begin
        x12        = {x_q[10], x_q};
        right_edge = x12 + $signed({2'b00, formationWidth}) + 12'(STEP_PX);
        left_edge  = x12 - 12'(STEP_PX);
        drop       = dir_q ? (right_edge > 12'(RIGHT_BOUND)) : (left_edge < 12'(LEFT_BOUND));
        y_drop     = {y_q[10], y_q} + 12'(DROP_PX);
        land       = (y_drop + $signed({3'b000, formationHeight})) >= 12'(FLOOR_Y);
        x_d        = (move_tick && !drop) ? (dir_q ? x_q + 11'(STEP_PX) : x_q - 11'(STEP_PX)) : x_q;
        y_d        = (move_tick && drop) ? y_drop[10:0] : y_q;
        dir_d      = (move_tick && drop) ? !dir_q : dir_q;
        state_d    = (aliveCount == 6'd0 && state_q != LANDED) ? CLEARED :
                     (state_q == IDLE && enable)              ? MARCH   :
                     (state_q == MARCH && !enable)            ? IDLE    :
                     (move_tick && drop && land)              ? LANDED  : state_q;
    end
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
            x_q     <= 11'(INIT_X);
            y_q     <= 11'(INIT_Y);
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            step_q  <= move_tick;
        end
    end
    assign topLeftX  = x_q;
    assign topLeftY  = y_q;
    assign direction = dir_q;
    assign stepPulse = step_q;
    assign landed    = (state_q == LANDED);
endmodule
